// File: rtl/mem_arbiter.sv
// mem_arbiter: byte-serial memory bus shared by instruction fetch and data load/store
module mem_arbiter (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        if_req_in,
    input  logic [31:0] if_addr_in,
    input  logic        if_flush_in,
    output logic        if_done_out,
    output logic [31:0] if_inst_out,
    input  logic        rd_req_in,
    input  logic        wr_req_in,
    input  logic [31:0] d_addr_in,
    input  logic [31:0] d_wdata_in,
    input  logic [1:0]  d_size_in,
    output logic        d_done_out,
    output logic [31:0] d_rdata_out,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full,
    output logic        busy_out
);
    typedef enum logic [1:0] {IDLE, IF_RD, D_RD, D_WR} state_t;
    state_t state, state_nxt;
    logic [2:0] icnt, icnt_nxt, ccnt, ccnt_nxt, n, n_nxt, cur_n, idx;
    logic [1:0] v, v_nxt;
    logic [31:0] base, base_nxt, wdata, wdata_nxt, data, data_nxt, a_q, a_nxt;
    logic [31:0] cur_addr, cur_wdata, byte_a;
    logic [7:0] dout_q, dout_nxt;
    logic wr_q, wr_nxt, if_done_q, if_done_nxt, d_done_q, d_done_nxt;
    logic idle, take_d, take_if, is_wr, active, issue, blocked, cap, fin;
    assign idle      = state == IDLE;
    assign take_d    = idle && !(if_done_q || d_done_q) && (rd_req_in || wr_req_in);
    assign take_if   = idle && !(if_done_q || d_done_q) && !take_d && if_req_in;
    assign is_wr     = idle ? take_d && wr_req_in : state == D_WR;
    assign cur_addr  = !idle ? base : take_d ? d_addr_in : if_addr_in;
    assign cur_n     = !idle ? n : !take_d ? 3'd4 : d_size_in[1] ? 3'd4 : d_size_in[0] ? 3'd2 : 3'd1;
    assign cur_wdata = idle ? d_wdata_in : wdata;
    assign idx       = idle ? 3'd0 : icnt;
    assign active    = take_d || take_if || (!idle && !(state == IF_RD && if_flush_in));
    assign issue     = active && idx < cur_n;
    assign byte_a    = cur_addr + {29'd0, idx};
    assign blocked   = issue && is_wr && byte_a[17:16] == 2'b11 && io_buffer_full;
    assign cap       = active && !is_wr && v[1];
    // A write is complete once its last byte has been held on the bus across an un-paused edge
    assign fin       = !idle && active && (is_wr ? icnt == n : cap && ccnt == n - 3'd1);
    always_ff @(posedge clk_in) begin
        if (rst_in)
            state <= IDLE;
        else if (rdy_in)
            state <= state_nxt;
    end
    always_comb begin
        state_nxt = take_d ? (wr_req_in ? D_WR : D_RD) : take_if ? IF_RD : (!active || fin) ? IDLE : state;
    end
    always_comb begin
        a_nxt       = issue ? byte_a : 32'd0;
        wr_nxt      = issue && is_wr && !blocked;
        dout_nxt    = !(issue && is_wr) ? 8'd0 :
                      idx[1] ? (idx[0] ? cur_wdata[31:24] : cur_wdata[23:16]) :
                               (idx[0] ? cur_wdata[15:8]  : cur_wdata[7:0]);
        icnt_nxt    = (!active || fin) ? 3'd0 : idx + {2'd0, issue && !blocked};
        ccnt_nxt    = (!active || fin) ? 3'd0 : ccnt + {2'd0, cap};
        v_nxt       = (!active || fin) ? 2'd0 : {v[0], issue && !is_wr};
        n_nxt       = cur_n;
        base_nxt    = cur_addr;
        wdata_nxt   = cur_wdata;
        if_done_nxt = fin && state == IF_RD;
        d_done_nxt  = fin && state != IF_RD;
        data_nxt    = (take_d || take_if) ? 32'd0 : data;
        if (cap)
            data_nxt[{ccnt[1:0], 3'b000} +: 8] = mem_din;
    end
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            icnt <= '0; ccnt <= '0; v <= '0; n <= '0; base <= '0; wdata <= '0; data <= '0;
            a_q <= '0; wr_q <= 1'b0; dout_q <= '0; if_done_q <= 1'b0; d_done_q <= 1'b0;
        end else if (rdy_in) begin
            icnt <= icnt_nxt; ccnt <= ccnt_nxt; v <= v_nxt; n <= n_nxt; base <= base_nxt;
            wdata <= wdata_nxt; data <= data_nxt; a_q <= a_nxt; wr_q <= wr_nxt; dout_q <= dout_nxt;
            if_done_q <= if_done_nxt; d_done_q <= d_done_nxt;
        end else begin
            // Bytes in flight are lost while paused, so rewind to the first one not yet captured/written
            icnt <= is_wr ? icnt - {2'd0, wr_q} : ccnt;
            v    <= 2'd0;
        end
    end
    assign mem_a       = a_q;
    assign mem_wr      = wr_q && rdy_in;
    assign mem_dout    = dout_q;
    assign busy_out    = !idle;
    assign if_done_out = if_done_q;
    assign d_done_out  = d_done_q;
    assign if_inst_out = if_done_q ? data : 32'd0;
    assign d_rdata_out = d_done_q ? data : 32'd0;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vectors against a one-cycle-latency byte RAM model
module tb_mem_arbiter;
    logic clk_in = 1'b0, rst_in = 1'b1, rdy_in = 1'b1;
    logic if_req_in = 1'b0, if_flush_in = 1'b0, rd_req_in = 1'b0, wr_req_in = 1'b0, io_buffer_full = 1'b0;
    logic [31:0] if_addr_in = 32'd0, d_addr_in = 32'd0, d_wdata_in = 32'd0;
    logic [1:0] d_size_in = 2'd0;
    logic [7:0] mem_din;
    logic if_done_out, d_done_out, mem_wr, busy_out;
    logic [31:0] if_inst_out, d_rdata_out, mem_a;
    logic [7:0] mem_dout;
    logic [7:0] ram [0:262143];
    int checks = 0, passed = 0;
    mem_arbiter dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .if_req_in(if_req_in), .if_addr_in(if_addr_in), .if_flush_in(if_flush_in),
        .if_done_out(if_done_out), .if_inst_out(if_inst_out),
        .rd_req_in(rd_req_in), .wr_req_in(wr_req_in), .d_addr_in(d_addr_in),
        .d_wdata_in(d_wdata_in), .d_size_in(d_size_in), .d_done_out(d_done_out),
        .d_rdata_out(d_rdata_out), .mem_din(mem_din), .mem_dout(mem_dout),
        .mem_a(mem_a), .mem_wr(mem_wr), .io_buffer_full(io_buffer_full), .busy_out(busy_out)
    );
    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) begin
        if (mem_wr)
            ram[mem_a[17:0]] <= mem_dout;
        mem_din <= ram[mem_a[17:0]];
    end
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp)
            passed++;
        else
            $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask
    initial begin
        for (int i = 0; i < 262144; i++) ram[i] = 8'h00;
        ram[18'h10] = 8'h13; ram[18'h11] = 8'h05; ram[18'h12] = 8'h00; ram[18'h13] = 8'h00;
        ram[18'h20] = 8'h11; ram[18'h21] = 8'h22; ram[18'h22] = 8'h33; ram[18'h23] = 8'h44;
        ram[18'h100] = 8'hEF; ram[18'h101] = 8'hBE; ram[18'h102] = 8'hAD; ram[18'h103] = 8'hDE;
        ram[18'h1FFFF] = 8'hA5; ram[18'h20000] = 8'h5A;
        // reset, with a request held to show reset wins
        if_req_in = 1'b1;
        tick(); tick();
        check("rst_busy", {31'd0, busy_out}, 32'd0);
        check("rst_mem_a", mem_a, 32'd0);
        check("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        check("rst_dones", {30'd0, if_done_out, d_done_out}, 32'd0);
        check("rst_rdata", d_rdata_out | if_inst_out, 32'd0);
        // plain word fetch
        rst_in = 1'b0; if_addr_in = 32'h10;
        tick();
        check("f_a0", mem_a, 32'h10);
        check("f_busy", {31'd0, busy_out}, 32'd1);
        if_req_in = 1'b0;
        tick(); check("f_a1", mem_a, 32'h11);
        tick(); check("f_a2", mem_a, 32'h12);
        tick(); check("f_a3", mem_a, 32'h13);
        tick(); check("f_a4", mem_a, 32'h0);
        check("f_early_done", {31'd0, if_done_out}, 32'd0);
        tick(); check("f_done", {31'd0, if_done_out}, 32'd1);
        check("f_inst", if_inst_out, 32'h00000513);
        tick(); check("f_done_gone", {31'd0, if_done_out}, 32'd0);
        check("f_inst_gone", if_inst_out, 32'd0);
        // data beats fetch on the same edge
        if_req_in = 1'b1; if_addr_in = 32'h10; rd_req_in = 1'b1; d_addr_in = 32'h100; d_size_in = 2'd2;
        tick(); check("arb_a0", mem_a, 32'h100);
        rd_req_in = 1'b0;
        tick(); tick(); tick(); tick();
        tick(); check("arb_ddone", {31'd0, d_done_out}, 32'd1);
        check("arb_rdata", d_rdata_out, 32'hDEADBEEF);
        check("arb_no_ifdone", {31'd0, if_done_out}, 32'd0);
        tick(); check("arb_gap_busy", {31'd0, busy_out}, 32'd0);
        check("arb_gap_a", mem_a, 32'd0);
        tick(); check("arb_fetch_a0", mem_a, 32'h10);
        if_req_in = 1'b0;
        tick(); tick(); tick(); tick();
        tick(); check("arb_fetch_inst", if_inst_out, 32'h00000513);
        tick();
        // IO store held off by a full UART; rd+wr together is a store
        io_buffer_full = 1'b1; wr_req_in = 1'b1; rd_req_in = 1'b1;
        d_addr_in = 32'h30000; d_size_in = 2'd0; d_wdata_in = 32'h41;
        tick(); check("io_a", mem_a, 32'h30000);
        check("io_wr0", {31'd0, mem_wr}, 32'd0);
        wr_req_in = 1'b0; rd_req_in = 1'b0;
        tick(); check("io_wr1", {31'd0, mem_wr}, 32'd0);
        tick(); check("io_wr2", {31'd0, mem_wr}, 32'd0);
        io_buffer_full = 1'b0;
        tick(); check("io_wr3", {31'd0, mem_wr}, 32'd1);
        check("io_dout", {24'd0, mem_dout}, 32'h41);
        tick(); check("io_done", {31'd0, d_done_out}, 32'd1);
        check("io_wr_off", {31'd0, mem_wr}, 32'd0);
        tick(); check("io_ram", {24'd0, ram[18'h30000]}, 32'h41);
        // flush a fetch at E2, then refetch immediately
        if_req_in = 1'b1; if_addr_in = 32'h10;
        tick(); if_req_in = 1'b0;
        tick(); if_flush_in = 1'b1;
        tick(); check("fl_busy", {31'd0, busy_out}, 32'd0);
        check("fl_a", mem_a, 32'd0);
        check("fl_done", {31'd0, if_done_out}, 32'd0);
        if_flush_in = 1'b0; if_req_in = 1'b1; if_addr_in = 32'h20;
        tick(); check("fl_new_a", mem_a, 32'h20);
        if_req_in = 1'b0;
        tick(); tick(); tick(); tick();
        tick(); check("fl_new_inst", if_inst_out, 32'h44332211);
        tick();
        // half-word load across a 64K line with a two-cycle pause
        rd_req_in = 1'b1; d_addr_in = 32'h1FFFF; d_size_in = 2'd1;
        tick(); check("st_a0", mem_a, 32'h1FFFF);
        rd_req_in = 1'b0;
        tick(); check("st_a1", mem_a, 32'h20000);
        rdy_in = 1'b0;
        tick(); check("st_hold_a", mem_a, 32'h20000);
        tick(); check("st_hold_busy", {31'd0, busy_out}, 32'd1);
        check("st_hold_done", {31'd0, d_done_out}, 32'd0);
        rdy_in = 1'b1;
        tick(); check("st_re_a0", mem_a, 32'h1FFFF);
        tick(); check("st_re_a1", mem_a, 32'h20000);
        tick(); check("st_early", {31'd0, d_done_out}, 32'd0);
        tick(); check("st_done", {31'd0, d_done_out}, 32'd1);
        check("st_rdata", d_rdata_out, 32'h00005AA5);
        tick();
        // fetch address wraps at 32 bits
        if_req_in = 1'b1; if_addr_in = 32'hFFFFFFFE;
        tick(); if_req_in = 1'b0;
        tick(); check("wrap_a1", mem_a, 32'hFFFFFFFF);
        tick(); check("wrap_a2", mem_a, 32'h0);
        tick(); tick();
        tick(); check("wrap_done", {31'd0, if_done_out}, 32'd1);
        tick();
        // reset in the middle of a word store
        wr_req_in = 1'b1; d_addr_in = 32'h200; d_size_in = 2'd2; d_wdata_in = 32'hCAFEBABE;
        tick(); check("ws_dout0", {24'd0, mem_dout}, 32'hBE);
        wr_req_in = 1'b0;
        tick(); check("ws_a1", mem_a, 32'h201);
        check("ws_dout1", {24'd0, mem_dout}, 32'hBA);
        rst_in = 1'b1;
        tick(); check("ws_rst_a", mem_a, 32'd0);
        check("ws_rst_wr", {31'd0, mem_wr}, 32'd0);
        check("ws_rst_dout", {24'd0, mem_dout}, 32'd0);
        check("ws_rst_busy", {31'd0, busy_out}, 32'd0);
        rst_in = 1'b0;
        tick(); check("ws_no_done", {31'd0, d_done_out}, 32'd0);
        check("ws_ram0", {24'd0, ram[18'h200]}, 32'hBE);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
